// File: rtl/nonogram_pkg.sv
// Shared definitions for the solution serializer.
//   - record flag encodings (top three bits of every 16-bit record)
//   - serializer FSM state type
//   - rec16(): packs {flag, idx, val} into one record
//   - byte_idx_w(): width of a byte index within one packed row
package nonogram_pkg;

    localparam int unsigned IDX_W = 12;

    localparam logic [2:0] FlagStart = 3'b111;
    localparam logic [2:0] FlagAnd   = 3'b101;
    localparam logic [2:0] FlagRow   = 3'b110;
    localparam logic [2:0] FlagEnd   = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StHdrM,
        StHdrN,
        StCell,
        StRowHdr,
        StRowData,
        StEnd
    } ser_state_t;

    function automatic logic [15:0] rec16(input logic [2:0]       flag,
                                          input logic [IDX_W-1:0] idx,
                                          input logic             val);
        return {flag, idx, val};
    endfunction

    // Never narrower than one bit, even when a row fits in a single byte.
    function automatic int unsigned byte_idx_w(input int unsigned cols);
        int unsigned nb;
        nb = (cols + 7) / 8;
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/solution_serializer_row_packer.sv
// row_packer: combinational extraction of one payload byte of a packed row.
//   sol_i      : board snapshot, cell (r,c) at bit r*MAX_COLS+c
//   row_i      : row r to pack
//   byte_idx_i : byte j within the row; bit k of the result is cell (r, 8j+k)
//   n_i        : columns in use; bits for columns >= n_i are forced to zero
//   byte_o     : packed byte
module row_packer
    import nonogram_pkg::*;
#(
    parameter int unsigned MAX_ROWS = 11,
    parameter int unsigned MAX_COLS = 11
) (
    input  logic [MAX_ROWS*MAX_COLS-1:0]      sol_i,
    input  logic [$clog2(MAX_ROWS+1)-1:0]     row_i,
    input  logic [byte_idx_w(MAX_COLS)-1:0]   byte_idx_i,
    input  logic [$clog2(MAX_COLS+1)-1:0]     n_i,
    output logic [7:0]                        byte_o
);

    localparam int unsigned RowBytes = (MAX_COLS + 7) / 8;
    localparam int unsigned RowW     = RowBytes * 8;

    logic [RowW-1:0] row_w;
    logic [RowW-1:0] mask;

    always_comb begin
        // Bits past MAX_COLS belong to the next row; the column mask clears them.
        row_w  = RowW'(sol_i >> (row_i * MAX_COLS));
        mask   = (RowW'(1) << n_i) - RowW'(1);
        byte_o = 8'((row_w & mask) >> {byte_idx_i, 3'b000});
    end

endmodule

// File: rtl/solution_serializer.sv
// solution_serializer: snapshots a solved board and streams it as 16-bit records,
// low byte first, over a valid/ready byte interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_in, in_ready  : frame request handshake (in_ready = ~busy)
//   mode                : 0 = per-cell records, 1 = packed-row bitmaps
//   solution, m, n      : board and its used dimensions, captured at accept
//   tx_valid, tx_ready  : byte handshake toward the UART
//   tx_data             : byte out, stable while stalled
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
module solution_serializer
    import nonogram_pkg::*;
#(
    parameter int unsigned MAX_ROWS = 11,
    parameter int unsigned MAX_COLS = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    output logic                            in_ready,
    input  logic                            mode,
    input  logic [MAX_ROWS*MAX_COLS-1:0]    solution,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   m,
    input  logic [$clog2(MAX_COLS+1)-1:0]   n,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [7:0]                      tx_data,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned Cells = MAX_ROWS * MAX_COLS;
    localparam int unsigned MW    = $clog2(MAX_ROWS + 1);
    localparam int unsigned NW    = $clog2(MAX_COLS + 1);
    localparam int unsigned AW    = $clog2(Cells);
    localparam int unsigned JW    = byte_idx_w(MAX_COLS);

    ser_state_t         state_q, state_d;
    logic               byte_sel_q, byte_sel_d;
    logic [Cells-1:0]   sol_q, sol_d;
    logic [MW-1:0]      m_q, m_d;
    logic [NW-1:0]      n_q, n_d;
    logic               mode_q, mode_d;
    logic [MW-1:0]      r_q, r_d;
    logic [NW-1:0]      c_q, c_d;
    logic [IDX_W-1:0]   rel_q, rel_d;
    logic [AW-1:0]      addr_q, addr_d;     // real bit index of cell (r,c) in sol_q
    logic [JW-1:0]      j_q, j_d;
    logic               done_q, done_d;

    logic               tx_fire;
    logic               last_col;
    logic               last_row;
    logic               last_byte;
    logic [JW-1:0]      last_j;
    logic [MW-1:0]      m_clamp;
    logic [NW-1:0]      n_clamp;
    logic [15:0]        rec;
    logic [7:0]         row_byte;

    assign m_clamp   = (m > MW'(MAX_ROWS)) ? MW'(MAX_ROWS) : m;
    assign n_clamp   = (n > NW'(MAX_COLS)) ? NW'(MAX_COLS) : n;

    assign tx_valid  = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign in_ready  = ~busy;
    assign done      = done_q;
    assign tx_fire   = tx_valid & tx_ready;

    // Only meaningful once m_q, n_q >= 1, which holds in every state that uses them.
    assign last_col  = (c_q == n_q - NW'(1));
    assign last_row  = (r_q == m_q - MW'(1));
    assign last_j    = JW'((32'(n_q) + 32'd7) / 32'd8 - 32'd1);
    assign last_byte = (j_q == last_j);

    row_packer #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS)
    ) u_row_packer (
        .sol_i      (sol_q),
        .row_i      (r_q),
        .byte_idx_i (j_q),
        .n_i        (n_q),
        .byte_o     (row_byte)
    );

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        byte_sel_d = byte_sel_q;
        sol_d      = sol_q;
        m_d        = m_q;
        n_d        = n_q;
        mode_d     = mode_q;
        r_d        = r_q;
        c_d        = c_q;
        rel_d      = rel_q;
        addr_d     = addr_q;
        j_d        = j_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (valid_in) begin
                    sol_d      = solution;
                    m_d        = m_clamp;
                    n_d        = n_clamp;
                    mode_d     = mode;
                    r_d        = '0;
                    c_d        = '0;
                    rel_d      = '0;
                    addr_d     = '0;
                    j_d        = '0;
                    byte_sel_d = 1'b0;
                    state_d    = StHdrM;
                end
            end

            StHdrM: begin
                if (tx_fire) begin
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        state_d = StHdrN;
                    end
                end
            end

            StHdrN: begin
                if (tx_fire) begin
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        if ((m_q == '0) || (n_q == '0)) begin
                            state_d = StEnd;
                        end else if (mode_q) begin
                            state_d = StRowHdr;
                        end else begin
                            state_d = StCell;
                        end
                    end
                end
            end

            StCell: begin
                if (tx_fire) begin
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        if (last_col && last_row) begin
                            state_d = StEnd;
                        end else if (last_col) begin
                            rel_d  = rel_q + IDX_W'(1);
                            r_d    = r_q + MW'(1);
                            c_d    = '0;
                            // Skip the unused tail of this row in the MAX_COLS-wide layout.
                            addr_d = addr_q + AW'(MAX_COLS + 1) - AW'(n_q);
                        end else begin
                            rel_d  = rel_q + IDX_W'(1);
                            c_d    = c_q + NW'(1);
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
            end

            StRowHdr: begin
                if (tx_fire) begin
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        j_d     = '0;
                        state_d = StRowData;
                    end
                end
            end

            // Raw payload bytes: one per handshake, byte_sel stays low.
            StRowData: begin
                if (tx_fire) begin
                    if (last_byte) begin
                        j_d = '0;
                        if (last_row) begin
                            state_d = StEnd;
                        end else begin
                            r_d     = r_q + MW'(1);
                            state_d = StRowHdr;
                        end
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end

            StEnd: begin
                if (tx_fire) begin
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output byte selection
    always_comb begin
        rec = 16'h0000;
        case (state_q)
            StHdrM:   rec = rec16(FlagStart, IDX_W'(m_q), 1'b0);
            StHdrN:   rec = rec16(FlagStart, IDX_W'(n_q), 1'b0);
            StCell:   rec = rec16(FlagAnd, rel_q, sol_q[addr_q]);
            StRowHdr: rec = rec16(FlagRow, IDX_W'(r_q), 1'b0);
            StEnd:    rec = rec16(FlagEnd, '0, 1'b0);
            default:  rec = 16'h0000;
        endcase

        if (state_q == StRowData) begin
            tx_data = row_byte;
        end else if (byte_sel_q) begin
            tx_data = rec[15:8];
        end else begin
            tx_data = rec[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_sel_q <= 1'b0;
            sol_q      <= '0;
            m_q        <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            r_q        <= '0;
            c_q        <= '0;
            rel_q      <= '0;
            addr_q     <= '0;
            j_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_sel_q <= byte_sel_d;
            sol_q      <= sol_d;
            m_q        <= m_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            r_q        <= r_d;
            c_q        <= c_d;
            rel_q      <= rel_d;
            addr_q     <= addr_d;
            j_q        <= j_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_solution_serializer.sv
// Directed bench for solution_serializer: per-cell frames, stalls, packed rows,
// empty boards, ignored requests while busy, clamping, full board and async reset.
module tb_solution_serializer;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic         in_ready;
    logic         mode;
    logic [120:0] solution;
    logic [3:0]   m;
    logic [3:0]   n;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   tx_data;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int done_cnt;
    int freeze_bad;
    int stall_cycles;
    int timed_out;

    solution_serializer #(
        .MAX_ROWS (11),
        .MAX_COLS (11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .in_ready (in_ready),
        .mode     (mode),
        .solution (solution),
        .m        (m),
        .n        (n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Request a frame, then scramble the inputs to show they were snapshotted.
    task automatic start_frame(input logic md, input logic [120:0] sol,
                               input logic [3:0] mm, input logic [3:0] nn);
        @(posedge clk); #1;
        mode     = md;
        solution = sol;
        m        = mm;
        n        = nn;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        mode     = ~md;
        solution = ~sol;
        m        = 4'd7;
        n        = 4'd9;
    endtask

    // Gather accepted bytes until done; optional stall of stall_len cycles once
    // stall_at bytes have been accepted.
    task automatic collect(input int stall_at, input int stall_len, input int budget);
        int cyc;
        int stalling;
        bit stalled;
        logic [7:0] held;
        got.delete();
        done_cnt = 0; freeze_bad = 0; stall_cycles = 0; timed_out = 0;
        cyc = 0; stalling = 0; stalled = 1'b0; held = 8'h00;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stalling > 0) begin
                stall_cycles++;
                if (tx_valid !== 1'b1 || tx_data !== held) freeze_bad++;
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_data);
            if (done === 1'b1) begin
                done_cnt++;
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            cyc++;
            @(posedge clk); #1;
            if (stalling > 0) stalling--;
            if (!stalled && stall_len > 0 && got.size() == stall_at) begin
                stalling = stall_len;
                stalled  = 1'b1;
                held     = tx_data;
            end
            tx_ready = (stalling == 0);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL idle_tx_valid got=%b want=0", tx_valid); end
    endtask

    task automatic test_cell_basic();
        logic [120:0] sol;
        sol = '0; sol[0] = 1'b1; sol[2] = 1'b1; sol[12] = 1'b1;
        exp_q = '{8'h04, 8'hE0, 8'h06, 8'hE0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h05,
                  8'hA0, 8'h06, 8'hA0, 8'h09, 8'hA0, 8'h0A, 8'hA0, 8'h00, 8'h00};
        start_frame(1'b0, sol, 4'd2, 4'd3);
        collect(0, 0, 200);
        total++; if (timed_out != 0) begin bad++; $display("FAIL cell_timeout got=%0d want=0", timed_out); end
        total++; if (got.size() != 18) begin bad++; $display("FAIL cell_count got=%0d want=18", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL cell_byte[%0d] got=%h want=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL cell_done got=%0d want=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cell_busy_at_done got=%b want=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cell_in_ready_at_done got=%b want=1", in_ready); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL cell_done_width got=%b want=0", done); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL cell_idle_valid got=%b want=0", tx_valid); end
    endtask

    task automatic test_stall();
        logic [120:0] sol;
        sol = '0; sol[0] = 1'b1; sol[2] = 1'b1; sol[12] = 1'b1;
        exp_q = '{8'h04, 8'hE0, 8'h06, 8'hE0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h05,
                  8'hA0, 8'h06, 8'hA0, 8'h09, 8'hA0, 8'h0A, 8'hA0, 8'h00, 8'h00};
        start_frame(1'b0, sol, 4'd2, 4'd3);
        collect(5, 3, 200);
        total++; if (timed_out != 0) begin bad++; $display("FAIL stall_timeout got=%0d want=0", timed_out); end
        total++; if (stall_cycles != 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", stall_cycles); end
        total++; if (freeze_bad != 0) begin bad++; $display("FAIL stall_frozen got=%0d want=0", freeze_bad); end
        total++; if (got.size() != 18) begin bad++; $display("FAIL stall_count got=%0d want=18", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_byte[%0d] got=%h want=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_packed_row();
        logic [120:0] sol;
        sol = '0;
        for (int c = 0; c < 11; c++) sol[c] = 1'b1;
        sol[21] = 1'b1;
        exp_q = '{8'h04, 8'hE0, 8'h16, 8'hE0, 8'h00, 8'hC0, 8'hFF, 8'h07,
                  8'h02, 8'hC0, 8'h00, 8'h04, 8'h00, 8'h00};
        start_frame(1'b1, sol, 4'd2, 4'd11);
        collect(0, 0, 200);
        total++; if (timed_out != 0) begin bad++; $display("FAIL row_timeout got=%0d want=0", timed_out); end
        total++; if (got.size() != 14) begin bad++; $display("FAIL row_count got=%0d want=14", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL row_byte[%0d] got=%h want=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_empty_busy();
        int extra;
        exp_q = '{8'h00, 8'hE0, 8'h0A, 8'hE0, 8'h00, 8'h00};
        start_frame(1'b0, {121{1'b1}}, 4'd0, 4'd5);
        fork
            collect(0, 0, 100);
            begin
                repeat (2) @(posedge clk);
                #2;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready); end
                valid_in = 1'b1;
                m = 4'd3; n = 4'd3;
                @(posedge clk); #2;
                valid_in = 1'b0;
            end
        join
        total++; if (timed_out != 0) begin bad++; $display("FAIL empty_timeout got=%0d want=0", timed_out); end
        total++; if (got.size() != 6) begin bad++; $display("FAIL empty_count got=%0d want=6", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL empty_byte[%0d] got=%h want=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_request_queued got=%0d want=0", extra); end
    endtask

    task automatic test_clamp();
        start_frame(1'b1, {121{1'b1}}, 4'd15, 4'd13);
        collect(0, 0, 300);
        total++; if (timed_out != 0) begin bad++; $display("FAIL clamp_timeout got=%0d want=0", timed_out); end
        total++; if (got.size() != 50) begin bad++; $display("FAIL clamp_count got=%0d want=50", got.size()); end
        if (got.size() >= 50) begin
            total++; if (got[0] !== 8'h16) begin bad++; $display("FAIL clamp_m got=%h want=16", got[0]); end
            total++; if (got[2] !== 8'h16) begin bad++; $display("FAIL clamp_n got=%h want=16", got[2]); end
            total++; if (got[44] !== 8'h14 || got[45] !== 8'hC0) begin
                bad++; $display("FAIL clamp_last_row_hdr got=%h%h want=C014", got[45], got[44]); end
            total++; if (got[46] !== 8'hFF || got[47] !== 8'h07) begin
                bad++; $display("FAIL clamp_last_row_data got=%h %h want=FF 07", got[46], got[47]); end
        end
    endtask

    task automatic test_full_board();
        logic [120:0] sol;
        logic [15:0]  rec;
        int rel;
        sol = '0;
        for (int i = 0; i < 121; i++) sol[i] = (i % 3 == 0);
        exp_q = '{8'h16, 8'hE0, 8'h16, 8'hE0};
        rel = 0;
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
                rec = {3'b101, 12'(rel), sol[r * 11 + c]};
                exp_q.push_back(rec[7:0]);
                exp_q.push_back(rec[15:8]);
                rel++;
            end
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        start_frame(1'b0, sol, 4'd11, 4'd11);
        collect(0, 0, 500);
        total++; if (timed_out != 0) begin bad++; $display("FAIL full_timeout got=%0d want=0", timed_out); end
        total++; if (got.size() != 248) begin bad++; $display("FAIL full_count got=%0d want=248", got.size()); end
        if (got.size() >= 246) begin
            total++; if (got[244] !== 8'hF1 || got[245] !== 8'hA0) begin
                bad++; $display("FAIL full_last_and got=%h %h want=F1 A0", got[244], got[245]); end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL full_byte[%0d] got=%h want=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [120:0] sol;
        int cnt;
        sol = '0; sol[0] = 1'b1; sol[2] = 1'b1; sol[12] = 1'b1;
        start_frame(1'b0, sol, 4'd2, 4'd3);
        tx_ready = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 50 && cnt < 5; cyc++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) cnt++;
        end
        total++; if (cnt != 5) begin bad++; $display("FAIL arst_progress got=%0d want=5", cnt); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL arst_tx_valid got=%b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(1'b0, sol, 4'd2, 4'd3);
        collect(0, 0, 200);
        total++; if (got.size() != 18) begin bad++; $display("FAIL arst_restart_count got=%0d want=18", got.size()); end
        if (got.size() >= 2) begin
            total++; if (got[0] !== 8'h04 || got[1] !== 8'hE0) begin
                bad++; $display("FAIL arst_restart_hdr got=%h %h want=04 E0", got[0], got[1]); end
        end
    endtask

    initial begin
        valid_in = 1'b0;
        mode     = 1'b0;
        solution = '0;
        m        = 4'd0;
        n        = 4'd0;
        tx_ready = 1'b1;
        test_reset();
        test_cell_basic();
        test_stall();
        test_packed_row();
        test_empty_busy();
        test_clamp();
        test_full_board();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
